// File: rtl/pc_seq_pkg.sv
// Shared definitions for the program-counter sequencer: next-PC select codes
// and default parameter values.
// Optional return-address stack is enabled with PC_SEQ_RET_STACK_EN.
package pc_seq_pkg;

   localparam int unsigned PC_W_DEF        = 8;
   localparam int unsigned STACK_DEPTH_DEF = 4;
   localparam int unsigned STACK_DEPTH_MAX = 16;

   // Source of the next program counter value.
   typedef enum logic [2:0] {
      SEL_HOLD = 3'd0,
      SEL_INC  = 3'd1,
      SEL_JUMP = 3'd2,
      SEL_CALL = 3'd3,
      SEL_RET  = 3'd4
   } sel_t;

   // Width of a counter that must represent 0..depth inclusive.
   function automatic int unsigned count_width(input int unsigned depth);
      return (depth < 1) ? 1 : $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/ret_addr_stack.sv
// Return-address LIFO for the PC sequencer. Only the occupancy count is
// reset; entry contents are don't-care until written. Push and pop are
// expected to be mutually exclusive and qualified by full/empty upstream.
module ret_addr_stack
   import pc_seq_pkg::*;
#(
   parameter int unsigned PC_W        = PC_W_DEF,
   parameter int unsigned STACK_DEPTH = STACK_DEPTH_DEF
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic                                   push,
   input  logic                                   pop,
   input  logic [PC_W-1:0]                        push_data,
   output logic [PC_W-1:0]                        top_data,
   output logic [count_width(STACK_DEPTH)-1:0]    count,
   output logic                                   full,
   output logic                                   empty
);

   localparam int unsigned CNT_W = count_width(STACK_DEPTH);
   localparam int unsigned IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

   logic [PC_W-1:0]  entries [STACK_DEPTH];
   logic [CNT_W-1:0] count_nxt;
   logic [IDX_W-1:0] wr_idx;
   logic [IDX_W-1:0] top_idx;

   // Write slot is the current count, top of stack is one below it.
   always_comb begin
      wr_idx    = count[IDX_W-1:0];
      top_idx   = IDX_W'(count - CNT_W'(1));
      count_nxt = count;
      if (push && !full) begin
         count_nxt = count + CNT_W'(1);
      end else if (pop && !empty) begin
         count_nxt = count - CNT_W'(1);
      end
   end

   // Top entry; only meaningful while the stack is not empty.
   always_comb begin
      top_data = '0;
      if (!empty) begin
         top_data = entries[top_idx];
      end
   end

   // Entry storage, no reset needed.
   always_ff @(posedge clk) begin
      if (push && !full) begin
         entries[wr_idx] <= push_data;
      end
   end

   // Occupancy count and registered full/empty flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
         full  <= 1'b0;
         empty <= 1'b1;
      end else begin
         count <= count_nxt;
         full  <= (count_nxt == CNT_W'(STACK_DEPTH));
         empty <= (count_nxt == '0);
      end
   end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: increment, jump, and (optionally) call/return
// through a return-address stack with sticky overflow/underflow fault.
// Define PC_SEQ_RET_STACK_EN to build in the return stack; without it call
// behaves as jump and return is ignored.
module pc_sequencer
   import pc_seq_pkg::*;
#(
   parameter int unsigned PC_W        = PC_W_DEF,
   parameter int unsigned STACK_DEPTH = STACK_DEPTH_DEF
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic                                   startbit,
   input  logic                                   wb_stage,
   input  logic                                   jump_flag,
   input  logic                                   call_flag,
   input  logic                                   ret_flag,
   input  logic [PC_W-1:0]                        jump_address,
   output logic [PC_W-1:0]                        pc,
   output logic                                   running,
   output logic [count_width(STACK_DEPTH)-1:0]    stack_count,
   output logic                                   stack_full,
   output logic                                   stack_empty,
   output logic                                   fault
);

   localparam int unsigned CNT_W = count_width(STACK_DEPTH);

   sel_t            sel;
   logic            advance;
   logic [PC_W-1:0] pc_inc;

   assign advance = running && wb_stage && !fault;
   assign pc_inc  = pc + PC_W'(1);

`ifdef PC_SEQ_RET_STACK_EN

   logic            push;
   logic            pop;
   logic [PC_W-1:0] top_data;

   // Next-PC select with ret > call > jump > increment priority.
   always_comb begin
      sel = SEL_HOLD;
      if (advance) begin
         if (ret_flag) begin
            sel = SEL_RET;
         end else if (call_flag) begin
            sel = SEL_CALL;
         end else if (jump_flag) begin
            sel = SEL_JUMP;
         end else begin
            sel = SEL_INC;
         end
      end
   end

   assign push = (sel == SEL_CALL) && !stack_full;
   assign pop  = (sel == SEL_RET)  && !stack_empty;

   ret_addr_stack #(
      .PC_W        (PC_W),
      .STACK_DEPTH (STACK_DEPTH)
   ) u_stack (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .pop       (pop),
      .push_data (pc_inc),
      .top_data  (top_data),
      .count     (stack_count),
      .full      (stack_full),
      .empty     (stack_empty)
   );

   // PC, run state and sticky fault; fault freezes everything until reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc      <= '0;
         running <= 1'b0;
         fault   <= 1'b0;
      end else begin
         if (startbit) begin
            running <= 1'b1;
         end
         case (sel)
            SEL_INC:  pc <= pc_inc;
            SEL_JUMP: pc <= jump_address;
            SEL_CALL: begin
               if (stack_full) begin
                  fault <= 1'b1;
               end else begin
                  pc <= jump_address;
               end
            end
            SEL_RET: begin
               if (stack_empty) begin
                  fault <= 1'b1;
               end else begin
                  pc <= top_data;
               end
            end
            default: pc <= pc;
         endcase
      end
   end

`else

   logic unused_ret_flag;

   assign unused_ret_flag = ret_flag;
   assign stack_count     = CNT_W'(0);
   assign stack_full      = 1'b0;
   assign stack_empty     = 1'b1;
   assign fault           = 1'b0;

   // Next-PC select: call degrades to jump, return is ignored.
   always_comb begin
      sel = SEL_HOLD;
      if (advance) begin
         if (call_flag || jump_flag) begin
            sel = SEL_JUMP;
         end else begin
            sel = SEL_INC;
         end
      end
   end

   // PC and run state.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc      <= '0;
         running <= 1'b0;
      end else begin
         if (startbit) begin
            running <= 1'b1;
         end
         case (sel)
            SEL_INC:  pc <= pc_inc;
            SEL_JUMP: pc <= jump_address;
            default:  pc <= pc;
         endcase
      end
   end

`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed testbench for pc_sequencer (PC_W=8, STACK_DEPTH=4). Covers both
// builds, selected by PC_SEQ_RET_STACK_EN.
module tb_pc_sequencer;

   logic       clk;
   logic       rst;
   logic       startbit;
   logic       wb_stage;
   logic       jump_flag;
   logic       call_flag;
   logic       ret_flag;
   logic [7:0] jump_address;
   logic [7:0] pc;
   logic       running;
   logic [2:0] stack_count;
   logic       stack_full;
   logic       stack_empty;
   logic       fault;

   int n_tests;
   int n_fail;

   pc_sequencer #(
      .PC_W        (8),
      .STACK_DEPTH (4)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .startbit     (startbit),
      .wb_stage     (wb_stage),
      .jump_flag    (jump_flag),
      .call_flag    (call_flag),
      .ret_flag     (ret_flag),
      .jump_address (jump_address),
      .pc           (pc),
      .running      (running),
      .stack_count  (stack_count),
      .stack_full   (stack_full),
      .stack_empty  (stack_empty),
      .fault        (fault)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // One clock edge, then settle so outputs are sampled away from the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_flags();
      jump_flag    = 1'b0;
      call_flag    = 1'b0;
      ret_flag     = 1'b0;
      jump_address = 8'h00;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic do_start();
      wb_stage = 1'b0;
      startbit = 1'b1;
      tick();
      startbit = 1'b0;
   endtask

   // Advance with a given flag combination.
   task automatic adv(input logic j, input logic c, input logic r, input logic [7:0] addr);
      wb_stage     = 1'b1;
      jump_flag    = j;
      call_flag    = c;
      ret_flag     = r;
      jump_address = addr;
      tick();
      wb_stage = 1'b0;
      clear_flags();
   endtask

   initial begin
      n_tests  = 0;
      n_fail   = 0;
      rst      = 1'b0;
      startbit = 1'b0;
      wb_stage = 1'b0;
      clear_flags();

      // Reset state
      do_reset();
      check("rst_pc", 32'(pc), 32'h00);
      check("rst_running", 32'(running), 32'h0);
      check("rst_count", 32'(stack_count), 32'h0);
      check("rst_empty", 32'(stack_empty), 32'h1);
      check("rst_full", 32'(stack_full), 32'h0);
      check("rst_fault", 32'(fault), 32'h0);

      // Advances while not running do nothing
      adv(1'b0, 1'b0, 1'b0, 8'h00);
      adv(1'b1, 1'b0, 1'b0, 8'h33);
      check("idle_pc", 32'(pc), 32'h00);
      check("idle_running", 32'(running), 32'h0);

      // Start, then five plain advances
      do_start();
      check("start_running", 32'(running), 32'h1);
      check("start_pc", 32'(pc), 32'h00);
      for (int i = 1; i <= 5; i++) begin
         adv(1'b0, 1'b0, 1'b0, 8'h00);
         check($sformatf("inc_%0d", i), 32'(pc), 32'(i));
      end

      // No strobe: hold
      tick();
      check("hold_no_wb", 32'(pc), 32'h05);

      // Wrap from all-ones
      adv(1'b1, 1'b0, 1'b0, 8'hFF);
      check("jump_ff", 32'(pc), 32'hFF);
      adv(1'b0, 1'b0, 1'b0, 8'h00);
      check("wrap_pc", 32'(pc), 32'h00);
      check("wrap_fault", 32'(fault), 32'h0);

      adv(1'b1, 1'b0, 1'b0, 8'h10);
      check("jump_10", 32'(pc), 32'h10);

`ifdef PC_SEQ_RET_STACK_EN
      // Call and return
      adv(1'b0, 1'b1, 1'b0, 8'h40);
      check("call_pc", 32'(pc), 32'h40);
      check("call_count", 32'(stack_count), 32'h1);
      check("call_empty", 32'(stack_empty), 32'h0);
      adv(1'b0, 1'b0, 1'b1, 8'h00);
      check("ret_pc", 32'(pc), 32'h11);
      check("ret_count", 32'(stack_count), 32'h0);

      // Four nested calls fill the stack; the fifth faults
      adv(1'b0, 1'b1, 1'b0, 8'h20);
      adv(1'b0, 1'b1, 1'b0, 8'h30);
      adv(1'b0, 1'b1, 1'b0, 8'h50);
      check("nest3_full", 32'(stack_full), 32'h0);
      adv(1'b0, 1'b1, 1'b0, 8'h60);
      check("nest4_pc", 32'(pc), 32'h60);
      check("nest4_count", 32'(stack_count), 32'h4);
      check("nest4_full", 32'(stack_full), 32'h1);
      adv(1'b0, 1'b1, 1'b0, 8'h70);
      check("ovf_fault", 32'(fault), 32'h1);
      check("ovf_pc", 32'(pc), 32'h60);
      check("ovf_count", 32'(stack_count), 32'h4);
      adv(1'b0, 1'b0, 1'b0, 8'h00);
      adv(1'b1, 1'b0, 1'b0, 8'h22);
      adv(1'b0, 1'b0, 1'b1, 8'h00);
      check("frozen_pc", 32'(pc), 32'h60);
      check("frozen_count", 32'(stack_count), 32'h4);
      check("frozen_fault", 32'(fault), 32'h1);

      // Reset clears fault
      do_reset();
      check("rst2_pc", 32'(pc), 32'h00);
      check("rst2_fault", 32'(fault), 32'h0);
      check("rst2_count", 32'(stack_count), 32'h0);
      check("rst2_running", 32'(running), 32'h0);

      // LIFO order: pushes 0x01 then 0x21
      do_start();
      adv(1'b0, 1'b1, 1'b0, 8'h20);
      adv(1'b0, 1'b1, 1'b0, 8'h30);
      check("lifo_pc", 32'(pc), 32'h30);
      adv(1'b0, 1'b0, 1'b1, 8'h00);
      check("lifo_ret1", 32'(pc), 32'h21);
      adv(1'b0, 1'b0, 1'b1, 8'h00);
      check("lifo_ret2", 32'(pc), 32'h01);
      check("lifo_empty", 32'(stack_empty), 32'h1);

      // All flags with empty stack: ret wins and underflows
      adv(1'b1, 1'b1, 1'b1, 8'h99);
      check("unf_fault", 32'(fault), 32'h1);
      check("unf_pc", 32'(pc), 32'h01);
      check("unf_count", 32'(stack_count), 32'h0);
      do_reset();
      check("rst3_pc", 32'(pc), 32'h00);
      check("rst3_fault", 32'(fault), 32'h0);
      check("rst3_running", 32'(running), 32'h0);

      // Reset on the same edge as a call
      do_start();
      rst = 1'b1;
      adv(1'b0, 1'b1, 1'b0, 8'h40);
      rst = 1'b0;
      check("rstcall_pc", 32'(pc), 32'h00);
      check("rstcall_count", 32'(stack_count), 32'h0);
      check("rstcall_running", 32'(running), 32'h0);
`else
      // Call degrades to jump, no stack
      adv(1'b0, 1'b1, 1'b0, 8'h40);
      check("call_pc", 32'(pc), 32'h40);
      check("call_count", 32'(stack_count), 32'h0);
      check("call_empty", 32'(stack_empty), 32'h1);
      check("call_full", 32'(stack_full), 32'h0);

      // Return alone increments
      adv(1'b0, 1'b0, 1'b1, 8'h00);
      check("ret_pc", 32'(pc), 32'h41);
      check("ret_fault", 32'(fault), 32'h0);

      // Return ignored, call takes effect as jump
      adv(1'b0, 1'b1, 1'b1, 8'h80);
      check("retcall_pc", 32'(pc), 32'h80);
      adv(1'b1, 1'b0, 1'b1, 8'h90);
      check("retjump_pc", 32'(pc), 32'h90);

      // Reset on the same edge as a call
      rst = 1'b1;
      adv(1'b0, 1'b1, 1'b0, 8'h40);
      rst = 1'b0;
      check("rstcall_pc", 32'(pc), 32'h00);
      check("rstcall_count", 32'(stack_count), 32'h0);
      check("rstcall_running", 32'(running), 32'h0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   // Watchdog so the run always ends.
   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter PC_W, default 8, program-counter and target-address width in bits.
REQ-002 Parameter STACK_DEPTH, default 4, return-address stack entries; legal range 1 to 16.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 startbit  input  1  level; sequencer becomes running on first sampled 1.
REQ-006 wb_stage  input  1  advance strobe; one PC update per cycle sampled high.
REQ-007 jump_flag  input  1  load jump_address on advance.
REQ-008 call_flag  input  1  push return address, load jump_address on advance.
REQ-009 ret_flag  input  1  pop return address into PC on advance.
REQ-010 jump_address  input  PC_W  jump/call target.
REQ-011 pc  output  PC_W  registered program counter.
REQ-012 running  output  1  sequencer active.
REQ-013 stack_count  output  clog2(STACK_DEPTH+1)  occupied stack entries.
REQ-014 stack_full / stack_empty  output  1 each  count==STACK_DEPTH / count==0.
REQ-015 fault  output  1  sticky stack overflow/underflow flag.

Function
REQ-016 running SHALL set on the edge where startbit=1 and rst=0; startbit while running has no effect.
REQ-017 An update SHALL occur only on edges where running=1, wb_stage=1, fault=0; otherwise pc and stack hold.
REQ-018 Update priority SHALL be ret_flag > call_flag > jump_flag > increment; lower-priority flags ignored when higher asserted.
REQ-019 Increment SHALL be pc+1 modulo 2^PC_W (all-ones wraps to 0, no fault).
REQ-020 Jump SHALL load jump_address; stack unchanged.
REQ-021 Call with stack not full SHALL push (pc+1) mod 2^PC_W and load jump_address in the same edge.
REQ-022 Ret with stack not empty SHALL load the top entry into pc and pop it.
REQ-023 Call when full SHALL set fault, suppress push, hold pc.
REQ-024 Ret when empty SHALL set fault, hold pc.
REQ-025 Latency SHALL be one cycle: new pc visible the cycle after the sampling edge.
REQ-026 Once fault=1, the block SHALL freeze pc, stack, running until rst.
REQ-027 stack_count, stack_full, stack_empty SHALL be derived from registered count, no combinational path from flag inputs.

Reset
REQ-028 rst=1 at an edge SHALL set pc=0, running=0, stack_count=0, fault=0, overriding all other inputs including mid-update.
REQ-029 Stack entry contents after reset are don't-care; only count is cleared.

Configuration
REQ-030 Macro PC_SEQ_RET_STACK_EN, when defined, SHALL compile in the return stack and REQ-021..REQ-024 behaviour.
REQ-031 Without PC_SEQ_RET_STACK_EN, call_flag SHALL act as jump_flag, ret_flag SHALL be ignored (next priority applies), stack_count=0, stack_empty=1, stack_full=0, fault held 0.

Structure
REQ-032 Shared package pc_seq_pkg SHALL hold the next-PC select enumeration (SEL_HOLD, SEL_INC, SEL_JUMP, SEL_CALL, SEL_RET) and default parameter constants.
REQ-033 The stack SHALL be a sub-module ret_addr_stack (parameters PC_W, STACK_DEPTH; push, pop, data in/out, count), instantiated only under PC_SEQ_RET_STACK_EN.

Verification (PC_W=8, STACK_DEPTH=4, macro defined unless stated)
REQ-034 rst, startbit=1, 5 advances, no flags -> pc 0,1,2,3,4,5; pc=0xFF plus advance -> 0x00, fault=0.
REQ-035 pc=0x10, call_flag+jump_address=0x40 on advance -> pc=0x40, stack_count=1; ret on next advance -> pc=0x11, stack_count=0.
REQ-036 Four nested calls then a fifth -> stack_full=1 after fourth; fifth sets fault=1, pc unchanged; further advances hold pc.
REQ-037 ret_flag+call_flag+jump_flag together at empty stack -> fault=1 (ret wins), pc held; rst -> pc=0, fault=0, running=0.
REQ-038 Advances with running=0 -> pc stays 0; rst asserted same edge as call -> count=0, pc=0.
REQ-039 Macro undefined: call_flag to 0x40 -> pc=0x40, stack_count=0; ret_flag alone -> pc increments, fault=0.
